ahb3_liten: RTL and testbench
=============================

# ahb3_liten

AHB3-Lite slave wrapping a single-port word-organised memory of MEM_DEPTH entries. It sits on the system AHB3-Lite bus as a zero-wait-state memory target. It returns a two-cycle ERROR response for illegal accesses. Address phase and data phase are pipelined per the AHB3-Lite protocol.

## Interface
- MEM_SIZE, 32: memory word width in bits; must equal HDATA_SIZE.
- MEM_DEPTH, 256: number of words; power of two.
- HADDR_SIZE, 32: address bus width.
- HDATA_SIZE, 32: data bus width.

- HCLK  in  1  single clock; all logic on the rising edge.
- HRESETn  in  1  asynchronous, active-high reset. The name is kept for the codebase; 1 = reset asserted.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data, valid in the data phase.
- HRDATA  out  HDATA_SIZE  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- HBURST  in  3  accepted and ignored; every beat carries its own address.
- HPROT  in  4  accepted and ignored.
- HTRANS  in  2  IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
- HREADY  in  1  bus ready; the top level ties it to HREADYOUT.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Transfer accept.** A transfer is accepted when HSEL & HREADY & HTRANS[1] are all 1 at a rising edge. On accept the slave registers HADDR, HWRITE and HSIZE for the data phase.
- **No-op cycles.** IDLE, BUSY or unselected cycles give an OKAY response with zero wait states. They cause no memory access.
- **Word index.** HADDR[log2(MEM_DEPTH)+1:2].
- **Byte lanes.** Little-endian. A byte access uses lane HADDR[1:0]. A half-word access uses lanes {HADDR[1],0} and {HADDR[1],1}.
- **Write.** At the edge ending the write data phase, only the enabled byte lanes of HWDATA are written into the stored word.
- **Read.**
  - The full addressed word is driven on HRDATA during the data phase, whatever HSIZE is.
  - HRDATA holds its value when no read is in its data phase.
- **Read-after-write.** If a read address phase coincides with the data phase of a write to the same word, the returned data includes the newly written bytes (forwarding).
- **Error conditions** (when AHB3LITEN_ERRCHK_EN is defined):
  - HSIZE > 2;
  - misaligned access: half-word with HADDR[0] = 1, or word with HADDR[1:0] ≠ 0;
  - HADDR ≥ 4·MEM_DEPTH.
- **Error response.**
  - Data-phase cycle 1: HREADYOUT = 0, HRESP = 1.
  - Cycle 2: HREADYOUT = 1, HRESP = 1.
  - Memory is not modified.
- **Response FSM.** States: IDLE/OKAY → (illegal accept) ERR1 → ERR2 → OKAY. The next transfer may be accepted at the end of ERR2.

## Timing
- **Reset values.** While reset is asserted: HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = OKAY, pending data phase cleared, all memory words = 0.
- **Legal transfers.** Zero wait states. A read accepted at edge N has valid HRDATA after edge N and is sampled at edge N+1.
- **Writes.** A write accepted at edge N commits HWDATA at edge N+1.
- **Back-to-back.** Transfers pipeline with one transfer per cycle.
- **HREADY low.** HREADY = 0 blocks address sampling; held address-phase signals are not re-accepted.
- **Reset mid-transfer.** The pending write is discarded and the outputs return to their reset values immediately.

## Configuration
- **Macro:** AHB3LITEN_ERRCHK_EN.
- **Defined:** the error checks and two-cycle ERROR response described above.
- **Undefined:**
  - HRESP is always 0 and HREADYOUT is always 1.
  - Addresses wrap modulo 4·MEM_DEPTH.
  - Misaligned low address bits are ignored: they are forced to zero for half and word accesses.
  - HSIZE > 2 is treated as a word access.

## Test plan
- **Reset values:** reset asserted → HREADYOUT = 1, HRESP = 0, HRDATA = 0; a read of 0x00 after reset returns 0x00000000.
- **Word write/read:** NONSEQ word write 0xDEADBEEF to 0x10, then read 0x10 → HRDATA = 0xDEADBEEF, HRESP = 0, no wait states.
- **Byte/half writes:**
  - Word write 0x00000000 to 0x20.
  - Byte write 0xAB to 0x21 (HWDATA = 0x0000AB00).
  - Half-word write 0x1234 to 0x22 (HWDATA = 0x12340000).
  - Read 0x20 → 0x1234AB00.
- **Forwarding:** write 0x55AA55AA to 0x30 immediately followed by a read of 0x30 → read returns 0x55AA55AA.
- **Error checks** (macro defined): a read of 0x400 (depth 256), or a word access to 0x02 → cycle 1 HREADYOUT = 0 / HRESP = 1, cycle 2 HREADYOUT = 1 / HRESP = 1; memory unchanged.
- **Ignored fields:** INCR4 burst writing 1, 2, 3, 4 to 0x40–0x4C with a BUSY cycle inserted → reads return 1, 2, 3, 4; the BUSY cycle gets an OKAY response with zero wait states.

Source files
------------

// File: rtl/ahb3_liten_if.sv
// ahb3_liten_if: AHB3-Lite bus signals between a master and the ahb3_liten memory slave.
interface ahb3_liten_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3_liten.sv
// ahb3_liten: zero-wait-state AHB3-Lite word memory slave with write-to-read forwarding.
// Define AHB3LITEN_ERRCHK_EN to enable illegal-access checks and the two-cycle ERROR response.
module ahb3_liten #(
    parameter int MEM_SIZE   = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input logic         HCLK,
    input logic         HRESETn,
    ahb3_liten_if.slave s
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

    state_t                state_q, state_d;
    logic [MEM_SIZE-1:0]   mem_q [MEM_DEPTH];
    logic [MEM_SIZE-1:0]   mem_d [MEM_DEPTH];
    logic                  pend_q, pend_d;
    logic                  wr_q, wr_d;
    logic [AW-1:0]         idx_q, idx_d, idx;
    logic [3:0]            be_q, be_d, be;
    logic [HDATA_SIZE-1:0] rdata_q, rdata_d, wmerge;
    logic                  accept, illegal;
    logic                  unused_ok;

    assign unused_ok = ^{s.HBURST, s.HPROT, s.HADDR};

    always_comb begin
        accept = s.HSEL & s.HREADY & s.HTRANS[1];
        idx    = s.HADDR[AW+1:2];
        // Sub-word lanes; misaligned low bits are simply dropped for half/word.
        be     = (s.HSIZE == 3'd0) ? 4'b0001 << s.HADDR[1:0] :
                 (s.HSIZE == 3'd1) ? (s.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef AHB3LITEN_ERRCHK_EN
        illegal = (s.HSIZE > 3'd2) |
                  ((s.HSIZE == 3'd1) & s.HADDR[0]) |
                  ((s.HSIZE == 3'd2) & (s.HADDR[1:0] != 2'd0)) |
                  ((s.HADDR >> (AW + 2)) != '0);
`else
        illegal = 1'b0;
`endif
        wmerge = mem_q[idx_q];
        for (int b = 0; b < 4; b++)
            if (be_q[b]) wmerge[8*b +: 8] = s.HWDATA[8*b +: 8];
        mem_d = mem_q;
        if (pend_q & wr_q) mem_d[idx_q] = wmerge;
        pend_d = accept & ~illegal;
        wr_d   = accept ? s.HWRITE : wr_q;
        idx_d  = accept ? idx : idx_q;
        be_d   = accept ? be : be_q;
        // A read landing on the word being written this cycle sees the new bytes.
        rdata_d = (accept & ~illegal & ~s.HWRITE) ?
                  ((pend_q & wr_q & (idx_q == idx)) ? wmerge : mem_q[idx]) : rdata_q;
        state_d = (state_q == ST_ERR1) ? ST_ERR2 :
                  (accept & illegal) ? ST_ERR1 : ST_OKAY;
    end

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            state_q <= ST_OKAY;
            mem_q   <= '{default: '0};
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    assign s.HRDATA    = rdata_q;
    assign s.HREADYOUT = state_q != ST_ERR1;
    assign s.HRESP     = state_q != ST_OKAY;
endmodule

// File: tb/tb_ahb3_liten.sv
// tb_ahb3_liten: directed vector table for ahb3_liten plus hand-written reset sequences.
module tb_ahb3_liten;
    localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2, S = 2'd3;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rdy;
        logic        resp;
    } vec_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    vec_t vq[$];

    ahb3_liten_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb3_liten dut (.HCLK(HCLK), .HRESETn(HRESETn), .s(bus));

    always #5 HCLK = ~HCLK;

    task automatic add(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic rdy = 1'b1, input logic resp = 1'b0,
                       input logic [2:0] burst = 3'd0);
        vec_t v;
        v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.burst = burst;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rdy = rdy; v.resp = resp;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.HSEL = v.sel; bus.HTRANS = v.trans; bus.HWRITE = v.wr; bus.HSIZE = v.size;
        bus.HBURST = v.burst; bus.HPROT = 4'h3; bus.HADDR = v.addr; bus.HWDATA = v.wdata;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic rdy, input logic resp, input logic [31:0] rd);
        cmp({nm, " hreadyout"}, {31'd0, bus.HREADYOUT}, {31'd0, rdy});
        cmp({nm, " hresp"}, {31'd0, bus.HRESP}, {31'd0, resp});
        cmp({nm, " hrdata"}, bus.HRDATA, rd);
    endtask

    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
        vec_t v;
        v.sel = sel; v.trans = trans; v.wr = wr; v.size = 3'd2; v.burst = 3'd0;
        v.addr = addr; v.wdata = wdata; v.rdata = '0; v.rdy = 1'b1; v.resp = 1'b0;
        drive(v);
    endtask

    initial begin
        // Basic word, byte/half, forwarding, burst with BUSY, unselected cycle.
        add(1, N, 0, 2, 32'h00, 32'h0, 32'h0);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h0);
        add(1, N, 1, 2, 32'h10, 32'h0, 32'h0);
        add(1, I, 0, 2, 32'h00, 32'hDEADBEEF, 32'h0);
        add(1, N, 0, 2, 32'h10, 32'h0, 32'h0);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'hDEADBEEF);
        add(1, N, 1, 2, 32'h20, 32'h0, 32'hDEADBEEF);
        add(1, N, 1, 0, 32'h21, 32'h0, 32'hDEADBEEF);
        add(1, N, 1, 1, 32'h22, 32'h0000AB00, 32'hDEADBEEF);
        add(1, N, 0, 2, 32'h20, 32'h12340000, 32'hDEADBEEF);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h1234AB00);
        add(1, N, 1, 2, 32'h30, 32'h0, 32'h1234AB00);
        add(1, N, 0, 2, 32'h30, 32'h55AA55AA, 32'h1234AB00);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h55AA55AA);
        add(1, N, 1, 2, 32'h40, 32'h0, 32'h55AA55AA, 1, 0, 3'd3);
        add(1, S, 1, 2, 32'h44, 32'h1, 32'h55AA55AA, 1, 0, 3'd3);
        add(1, B, 1, 2, 32'h48, 32'h2, 32'h55AA55AA, 1, 0, 3'd3);
        add(1, S, 1, 2, 32'h48, 32'hFFFFFFFF, 32'h55AA55AA, 1, 0, 3'd3);
        add(1, S, 1, 2, 32'h4C, 32'h3, 32'h55AA55AA, 1, 0, 3'd3);
        add(1, N, 0, 2, 32'h40, 32'h4, 32'h55AA55AA, 1, 0, 3'd3);
        add(1, S, 0, 2, 32'h44, 32'h0, 32'h1, 1, 0, 3'd3);
        add(1, S, 0, 2, 32'h48, 32'h0, 32'h2, 1, 0, 3'd3);
        add(1, S, 0, 2, 32'h4C, 32'h0, 32'h3, 1, 0, 3'd3);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h4);
        add(0, N, 1, 2, 32'h40, 32'h0, 32'h4);
        add(1, I, 0, 2, 32'h00, 32'hFFFFFFFF, 32'h4);
        add(1, N, 0, 2, 32'h40, 32'h0, 32'h4);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h1);
`ifdef AHB3LITEN_ERRCHK_EN
        add(1, N, 0, 2, 32'h400, 32'h0, 32'h1);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h1, 0, 1);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h1, 1, 1);
        add(1, N, 1, 2, 32'h02, 32'h0, 32'h1);
        add(1, N, 1, 2, 32'h00, 32'hFFFFFFFF, 32'h1, 0, 1);
        add(1, N, 0, 2, 32'h00, 32'hFFFFFFFF, 32'h1, 1, 1);
        add(1, I, 0, 2, 32'h00, 32'hFFFFFFFF, 32'h0);
        add(1, N, 0, 3, 32'h40, 32'h0, 32'h0);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h0, 0, 1);
        add(1, N, 0, 1, 32'h41, 32'h0, 32'h0, 1, 1);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h0, 0, 1);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h0, 1, 1);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h0);
`else
        add(1, N, 1, 2, 32'h452, 32'h0, 32'h1);
        add(1, I, 0, 2, 32'h00, 32'hCAFEF00D, 32'h1);
        add(1, N, 1, 1, 32'h51, 32'h0, 32'h1);
        add(1, I, 0, 2, 32'h00, 32'h0000BEEF, 32'h1);
        add(1, N, 1, 3, 32'h54, 32'h0, 32'h1);
        add(1, N, 0, 2, 32'h50, 32'h11223344, 32'h1);
        add(1, N, 0, 2, 32'h54, 32'h0, 32'hCAFEBEEF);
        add(1, I, 0, 2, 32'h00, 32'h0, 32'h11223344);
`endif

        step(1, I, 0, 32'h0, 32'h0);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset", 1'b1, 1'b0, 32'h0);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;

        foreach (vq[i]) begin
            drive(vq[i]);
            @(negedge HCLK);
            chk($sformatf("v%0d", i), vq[i].rdy, vq[i].resp, vq[i].rdata);
            @(posedge HCLK); #1;
        end

        // Reset in the middle of a write data phase clears outputs and memory at once.
        step(1, N, 0, 32'h40, 32'h0);
        @(posedge HCLK); #1;
        step(1, N, 1, 32'h60, 32'h0);
        @(negedge HCLK);
        chk("pre_rst", 1'b1, 1'b0, 32'h1);
        @(posedge HCLK); #1;
        step(1, I, 0, 32'h0, 32'h12345678);
        #2 HRESETn = 1'b1;
        #1 chk("mid_rst", 1'b1, 1'b0, 32'h0);
        @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b0;
        @(posedge HCLK); #1;
        step(1, N, 0, 32'h40, 32'h0);
        @(posedge HCLK); #1;
        step(1, N, 0, 32'h60, 32'h0);
        @(negedge HCLK);
        chk("post_rst_40", 1'b1, 1'b0, 32'h0);
        @(posedge HCLK); #1;
        step(1, I, 0, 32'h0, 32'h0);
        @(negedge HCLK);
        chk("post_rst_60", 1'b1, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
